// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: producer offer, consumer take, and flush.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  modport master (
    output in_valid, in_pc, in_data, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_data, count
  );

  modport slave (
    input  in_valid, in_pc, in_data, flush, out_ready,
    output in_ready, out_valid, out_pc, out_data, count
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register with flush; all outputs come straight from flops.
// Optional PIPE_STAGE_REPLAY_PC_EN: flush loads out_pc with in_pc - PC_STEP instead of RESET_PC.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] BUBBLE   = '0,
  parameter logic [31:0]      RESET_PC = 32'h8000_0000,
  parameter logic [31:0]      PC_STEP  = 32'd4
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

`ifdef PIPE_STAGE_REPLAY_PC_EN
  localparam bit ReplayEn = 1'b1;
`else
  localparam bit ReplayEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stateT;

  stateT            state;
  logic             inReadyQ;
  logic             outValidQ;
  logic [1:0]       countQ;
  logic [31:0]      mainPc;
  logic [WIDTH-1:0] mainData;
  logic [31:0]      skidPc;
  logic [WIDTH-1:0] skidData;

  logic        accept;
  logic        pop;
  logic [31:0] flushPc;

  assign accept  = bus.in_valid & inReadyQ;
  assign pop     = outValidQ & bus.out_ready;
  // Replay target wraps modulo 2^32, so in_pc = 0 yields 32'hFFFF_FFFC.
  assign flushPc = ReplayEn ? (bus.in_pc - PC_STEP) : RESET_PC;

  // NOTE: every register below uses non-blocking assignment so all state updates
  // see pre-edge values; mixing in blocking writes would make skid->main ordering racy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      countQ    <= 2'd0;
      mainPc    <= RESET_PC;
      // NOTE: the payload registers are reset on purpose: out_data must read BUBBLE
      // straight out of reset, and a cleared skid keeps stale data from ever resurfacing.
      mainData  <= BUBBLE;
      skidPc    <= RESET_PC;
      skidData  <= BUBBLE;
    end else if (bus.flush) begin
      state     <= EMPTY;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      countQ    <= 2'd0;
      mainPc    <= flushPc;
      mainData  <= BUBBLE;
      skidData  <= BUBBLE;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            outValidQ <= 1'b1;
            countQ    <= 2'd1;
            mainPc    <= bus.in_pc;
            mainData  <= bus.in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            mainPc   <= bus.in_pc;
            mainData <= bus.in_data;
          end else if (accept) begin
            state    <= FULL;
            inReadyQ <= 1'b0;
            countQ   <= 2'd2;
            skidPc   <= bus.in_pc;
            skidData <= bus.in_data;
          end else if (pop) begin
            // out_pc deliberately keeps the departed entry's PC.
            state     <= EMPTY;
            outValidQ <= 1'b0;
            countQ    <= 2'd0;
            mainData  <= BUBBLE;
          end
        end
        FULL: begin
          if (pop) begin
            state    <= ONE;
            inReadyQ <= 1'b1;
            countQ   <= 2'd1;
            mainPc   <= skidPc;
            mainData <= skidData;
            skidData <= BUBBLE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = inReadyQ;
  assign bus.out_valid = outValidQ;
  assign bus.count     = countQ;
  assign bus.out_pc    = mainPc;
  assign bus.out_data  = mainData;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model compared every cycle, plus directed literal checks.
module tb_pipe_stage_reg;
  localparam int unsigned WIDTH    = 64;
  localparam logic [63:0] BUBBLE   = 64'hB0B0_B0B0_0000_0BAD;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

`ifdef PIPE_STAGE_REPLAY_PC_EN
  localparam bit          REPLAY       = 1'b1;
  localparam logic [63:0] EXP_FLUSH_PC = 64'h0040_000C;
  localparam logic [63:0] EXP_ZERO_PC  = 64'hFFFF_FFFC;
`else
  localparam bit          REPLAY       = 1'b0;
  localparam logic [63:0] EXP_FLUSH_PC = 64'h8000_0000;
  localparam logic [63:0] EXP_ZERO_PC  = 64'h8000_0000;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.WIDTH(WIDTH)) bus ();

  pipe_stage_reg #(
    .WIDTH    (WIDTH),
    .BUBBLE   (BUBBLE),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the stage is a FIFO of at most two {pc,data} entries.
  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
  } entryT;

  entryT       q[$];
  logic [31:0] holdPc;
  bit          modelOn = 1'b0;
  int          n;
  bit          acc;
  bit          pop;
  logic [63:0] expData;
  logic [63:0] expPc;

  // At each falling edge: compare against the model, then advance it with the
  // inputs that the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      n = q.size();
      if (modelOn) begin
        if (n > 0) begin
          expData = q[0].data;
          expPc   = 64'(q[0].pc);
        end else begin
          expData = BUBBLE;
          expPc   = 64'(holdPc);
        end
        check("mdl out_valid", 64'(bus.out_valid), 64'(n != 0));
        check("mdl count",     64'(bus.count),     64'(n));
        check("mdl in_ready",  64'(bus.in_ready),  64'(n < 2));
        check("mdl out_data",  bus.out_data,       expData);
        check("mdl out_pc",    64'(bus.out_pc),    expPc);
      end
      if (reset) begin
        q.delete();
        holdPc  = RESET_PC;
        modelOn = 1'b1;
      end else if (modelOn) begin
        acc = bus.in_valid && (n < 2);
        pop = (n > 0) && bus.out_ready;
        if (bus.flush) begin
          q.delete();
          holdPc = REPLAY ? (bus.in_pc - PC_STEP) : RESET_PC;
        end else begin
          if (pop) begin
            holdPc = q[0].pc;
            void'(q.pop_front());
          end
          if (acc) q.push_back('{pc: bus.in_pc, data: bus.in_data});
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset in_ready",  64'(bus.in_ready),  64'd1);
    check("reset count",     64'(bus.count),     64'd0);
    check("reset out_data",  bus.out_data,       BUBBLE);
    check("reset out_pc",    64'(bus.out_pc),    64'h8000_0000);
    reset = 1'b0;
    cyc();
    check("post-reset in_ready", 64'(bus.in_ready), 64'd1);

    // Back-to-back stream with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 64'(32'h11 + i);
      bus.in_pc    = 32'h0000_1000 + 32'(4 * i);
      cyc();
      check("stream out_data", bus.out_data, 64'(32'h11 + i));
      check("stream count",    64'(bus.count), 64'd1);
    end
    bus.in_valid = 1'b0;
    cyc();
    check("drain out_valid", 64'(bus.out_valid), 64'd0);
    check("drain out_data",  bus.out_data,       BUBBLE);
    check("drain out_pc",    64'(bus.out_pc),    64'h0000_1010);

    // Fill both entries while stalled, then release.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hA1;
    bus.in_pc     = 32'h0000_2000;
    cyc();
    bus.in_data   = 64'hA2;
    bus.in_pc     = 32'h0000_2004;
    cyc();
    bus.in_valid  = 1'b0;
    check("full count",    64'(bus.count),    64'd2);
    check("full in_ready", 64'(bus.in_ready), 64'd0);
    check("full out_data", bus.out_data,      64'hA1);
    bus.out_ready = 1'b1;
    #1;
    check("in_ready comb-indep of out_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    check("pop1 out_data", bus.out_data,      64'hA2);
    check("pop1 in_ready", 64'(bus.in_ready), 64'd1);
    check("pop1 count",    64'(bus.count),    64'd1);
    cyc();
    check("pop2 out_valid", 64'(bus.out_valid), 64'd0);
    check("pop2 out_pc",    64'(bus.out_pc),    64'h0000_2004);

    // Flush from FULL with a competing offer.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hB1;
    bus.in_pc     = 32'h0000_3000;
    cyc();
    bus.in_data   = 64'hB2;
    bus.in_pc     = 32'h0000_3004;
    cyc();
    bus.flush     = 1'b1;
    bus.in_data   = 64'hCC;
    bus.in_pc     = 32'h0040_0010;
    cyc();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    check("flush count",     64'(bus.count),     64'd0);
    check("flush out_valid", 64'(bus.out_valid), 64'd0);
    check("flush out_data",  bus.out_data,       BUBBLE);
    check("flush out_pc",    64'(bus.out_pc),    EXP_FLUSH_PC);
    cyc();
    check("flush drop out_valid", 64'(bus.out_valid), 64'd0);

    // Replay PC wrap at in_pc = 0.
    bus.flush = 1'b1;
    bus.in_pc = 32'h0;
    cyc();
    bus.flush = 1'b0;
    check("flush pc0 out_pc", 64'(bus.out_pc), EXP_ZERO_PC);

    // Reset beats flush and pop in the same cycle.
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hD1;
    bus.in_pc     = 32'h0000_5000;
    cyc();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    reset         = 1'b1;
    cyc();
    reset         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("rst+flush out_pc",    64'(bus.out_pc),    64'h8000_0000);
    check("rst+flush count",     64'(bus.count),     64'd0);
    check("rst+flush in_ready",  64'(bus.in_ready),  64'd1);
    check("rst+flush out_valid", 64'(bus.out_valid), 64'd0);
    check("rst+flush out_data",  bus.out_data,       BUBBLE);

    // Random traffic with occasional flushes; the model checks every cycle.
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.flush     = ($urandom_range(0, 63) == 0);
      bus.in_pc     = $urandom;
      bus.in_data   = {$urandom, $urandom};
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
